// File: rtl/cla_16_bit_msb.sv
// ---------------------------------------------------------------------------
// cla_16_bit_msb
//
// Purpose:
//   16-bit ALU slice with registered outputs and one clock of latency. The
//   arithmetic path is a two-level carry-lookahead adder: four 4-bit groups
//   produce group propagate/generate, and a second-level lookahead unit
//   derives every group carry-in directly from those, so there is no ripple
//   chain between groups. The flags (c_out, overflow, slt) come from the
//   most significant bit position.
//
// Ports:
//   clk      in   1   rising-edge clock; inputs sampled, outputs registered
//   rst_n    in   1   asynchronous active-low reset, clears all outputs
//   a        in  16   operand A (two's complement)
//   b        in  16   operand B (two's complement)
//   c_in     in   1   carry-in, used by ADD only
//   ALUop    in   3   000 AND, 001 OR, 010 ADD, 011 XOR,
//                     100 NOR, 101 SUB, 110 NAND, 111 SLT
//   result   out 16   registered result
//   c_out    out  1   registered carry out of bit 15 (0 for logical ops)
//   overflow out  1   registered signed overflow (0 for logical ops)
//   slt      out  1   registered signed a<b (SUB/SLT only, else 0)
// ---------------------------------------------------------------------------
module cla_16_bit_msb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    input  logic [2:0]  ALUop,
    output logic [15:0] result,
    output logic        c_out,
    output logic        overflow,
    output logic        slt
);

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpAdd  = 3'b010,
        OpXor  = 3'b011,
        OpNor  = 3'b100,
        OpSub  = 3'b101,
        OpNand = 3'b110,
        OpSlt  = 3'b111
    } alu_op_e;

    alu_op_e op;
    assign op = alu_op_e'(ALUop);

    // -----------------------------------------------------------------------
    // Operation decode
    // -----------------------------------------------------------------------
    logic is_add;
    logic is_sub;    // SUB or SLT: both compute a + ~b + 1
    logic is_arith;

    always_comb begin
        is_add   = (op == OpAdd);
        is_sub   = (op == OpSub) || (op == OpSlt);
        is_arith = is_add || is_sub;
    end

    // -----------------------------------------------------------------------
    // Adder operands. Subtraction inverts b and forces the carry-in to 1;
    // c_in only matters for ADD.
    // -----------------------------------------------------------------------
    logic [15:0] b_eff;
    logic        cin_eff;

    always_comb begin
        b_eff   = is_sub ? ~b : b;
        cin_eff = is_add ? c_in : is_sub;
    end

    // -----------------------------------------------------------------------
    // Bit-level propagate / generate
    // -----------------------------------------------------------------------
    logic [15:0] bit_p;
    logic [15:0] bit_g;

    always_comb begin
        bit_p = a ^ b_eff;
        bit_g = a & b_eff;
    end

    // -----------------------------------------------------------------------
    // Group propagate / generate for the four 4-bit groups
    // -----------------------------------------------------------------------
    logic [3:0] grp_p;
    logic [3:0] grp_g;

    always_comb begin
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < 4; k++) begin
            grp_p[k] = bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_p[4*k];
            grp_g[k] = bit_g[4*k+3]
                     | (bit_p[4*k+3] & bit_g[4*k+2])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
        end
    end

    // -----------------------------------------------------------------------
    // Second-level lookahead: every group carry-in and the final carry are
    // sum-of-products of group P/G and the adder carry-in, fully expanded.
    // -----------------------------------------------------------------------
    logic [3:0] grp_cin;
    logic       carry_16;

    always_comb begin
        grp_cin[0] = cin_eff;
        grp_cin[1] = grp_g[0]
                   | (grp_p[0] & cin_eff);
        grp_cin[2] = grp_g[1]
                   | (grp_p[1] & grp_g[0])
                   | (grp_p[1] & grp_p[0] & cin_eff);
        grp_cin[3] = grp_g[2]
                   | (grp_p[2] & grp_g[1])
                   | (grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[2] & grp_p[1] & grp_p[0] & cin_eff);
        carry_16   = grp_g[3]
                   | (grp_p[3] & grp_g[2])
                   | (grp_p[3] & grp_p[2] & grp_g[1])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin_eff);
    end

    // -----------------------------------------------------------------------
    // In-group lookahead: carry into each bit, from the group carry-in.
    // bit_c[i] is the carry INTO bit i.
    // -----------------------------------------------------------------------
    logic [15:0] bit_c;

    always_comb begin
        bit_c = '0;
        for (int k = 0; k < 4; k++) begin
            bit_c[4*k]   = grp_cin[k];
            bit_c[4*k+1] = bit_g[4*k]
                         | (bit_p[4*k] & grp_cin[k]);
            bit_c[4*k+2] = bit_g[4*k+1]
                         | (bit_p[4*k+1] & bit_g[4*k])
                         | (bit_p[4*k+1] & bit_p[4*k] & grp_cin[k]);
            bit_c[4*k+3] = bit_g[4*k+2]
                         | (bit_p[4*k+2] & bit_g[4*k+1])
                         | (bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k])
                         | (bit_p[4*k+2] & bit_p[4*k+1] & bit_p[4*k] & grp_cin[k]);
        end
    end

    // -----------------------------------------------------------------------
    // Sum and MSB flags
    // -----------------------------------------------------------------------
    logic [15:0] sum;
    logic        ovf_raw;

    always_comb begin
        sum     = bit_p ^ bit_c;
        // Signed overflow: carry into the sign bit differs from carry out.
        ovf_raw = bit_c[15] ^ carry_16;
    end

    // -----------------------------------------------------------------------
    // Next-state for the registered outputs
    // -----------------------------------------------------------------------
    logic [15:0] result_d;
    logic        c_out_d;
    logic        overflow_d;
    logic        slt_d;

    always_comb begin
        c_out_d    = is_arith & carry_16;
        overflow_d = is_arith & ovf_raw;
        // True signed less-than: sign of the difference corrected by overflow.
        slt_d      = is_sub & (sum[15] ^ ovf_raw);

        result_d = '0;
        unique case (op)
            OpAnd:   result_d = a & b;
            OpOr:    result_d = a | b;
            OpAdd:   result_d = sum;
            OpXor:   result_d = a ^ b;
            OpNor:   result_d = ~(a | b);
            OpSub:   result_d = sum;
            OpNand:  result_d = ~(a & b);
            OpSlt:   result_d = {15'b0, slt_d};
            default: result_d = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    logic [15:0] result_q;
    logic        c_out_q;
    logic        overflow_q;
    logic        slt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            c_out_q    <= 1'b0;
            overflow_q <= 1'b0;
            slt_q      <= 1'b0;
        end else begin
            result_q   <= result_d;
            c_out_q    <= c_out_d;
            overflow_q <= overflow_d;
            slt_q      <= slt_d;
        end
    end

    assign result   = result_q;
    assign c_out    = c_out_q;
    assign overflow = overflow_q;
    assign slt      = slt_q;

endmodule

// File: tb/tb_cla_16_bit_msb.sv
// ---------------------------------------------------------------------------
// tb_cla_16_bit_msb
//
// Directed bench for cla_16_bit_msb. Inputs change mid-cycle, outputs are
// sampled 1 time unit after the rising edge. All expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_cla_16_bit_msb;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic [2:0]  ALUop;
    logic [15:0] result;
    logic        c_out;
    logic        overflow;
    logic        slt;

    int total;
    int bad;

    cla_16_bit_msb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .ALUop    (ALUop),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow),
        .slt      (slt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] er, input logic ec,
                         input logic eo, input logic es);
        total++;
        assert (result === er) else begin
            bad++;
            $error("FAIL %s result: got %h want %h", tag, result, er);
        end
        total++;
        assert (c_out === ec) else begin
            bad++;
            $error("FAIL %s c_out: got %b want %b", tag, c_out, ec);
        end
        total++;
        assert (overflow === eo) else begin
            bad++;
            $error("FAIL %s overflow: got %b want %b", tag, overflow, eo);
        end
        total++;
        assert (slt === es) else begin
            bad++;
            $error("FAIL %s slt: got %b want %b", tag, slt, es);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] va, input logic [15:0] vb,
                         input logic ci);
        ALUop = op;
        a     = va;
        b     = vb;
        c_in  = ci;
    endtask

    // Apply inputs mid-cycle, clock once, sample just after the edge.
    task automatic run(input logic [2:0] op, input logic [15:0] va, input logic [15:0] vb,
                       input logic ci);
        drive(op, va, vb, ci);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset asserted from time 0 with a live operation on the inputs.
        rst_n = 1'b0;
        drive(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        #2;
        check("reset_t0", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_edge", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Release between edges; first edge captures normally.
        rst_n = 1'b1;
        run(OP_SUB, 16'h7FFF, 16'h7FFF, 1'b0);
        check("sub_equal", 16'h0000, 1'b1, 1'b0, 1'b0);

        run(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        check("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);

        // Outputs hold while inputs change between edges.
        drive(OP_AND, 16'h0000, 16'h0000, 1'b1);
        #3;
        check("hold", 16'h8000, 1'b0, 1'b1, 1'b0);

        run(OP_ADD, 16'hFFFF, 16'h0000, 1'b1);
        check("add_cin_cout", 16'h0000, 1'b1, 1'b0, 1'b0);

        run(OP_SUB, 16'h8000, 16'h0001, 1'b0);
        check("sub_ovf_slt", 16'h7FFF, 1'b1, 1'b1, 1'b1);

        run(OP_SLT, 16'hFFFF, 16'h0001, 1'b0);
        check("slt_neg", 16'h0001, 1'b1, 1'b0, 1'b1);

        run(OP_SLT, 16'h8000, 16'h0001, 1'b1);
        check("slt_ovf", 16'h0001, 1'b1, 1'b1, 1'b1);

        run(OP_SLT, 16'h0001, 16'hFFFF, 1'b0);
        check("slt_false", 16'h0000, 1'b0, 1'b0, 1'b0);

        // c_in must be ignored by SUB: 5 - 3 = 2.
        run(OP_SUB, 16'h0005, 16'h0003, 1'b1);
        check("sub_cin_ignored", 16'h0002, 1'b1, 1'b0, 1'b0);

        run(OP_ADD, 16'h1234, 16'h4321, 1'b0);
        check("add_plain", 16'h5555, 1'b0, 1'b0, 1'b0);

        run(OP_ADD, 16'h8000, 16'h8000, 1'b0);
        check("add_neg_ovf", 16'h0000, 1'b1, 1'b1, 1'b0);

        // Carries crossing group boundaries.
        run(OP_ADD, 16'h00FF, 16'h0001, 1'b0);
        check("add_grp1", 16'h0100, 1'b0, 1'b0, 1'b0);
        run(OP_ADD, 16'h0FFF, 16'h0000, 1'b1);
        check("add_grp3", 16'h1000, 1'b0, 1'b0, 1'b0);
        run(OP_ADD, 16'h000F, 16'h0001, 1'b0);
        check("add_grp0", 16'h0010, 1'b0, 1'b0, 1'b0);

        // Logical ops: flags forced to 0 (c_in set to catch leakage).
        run(OP_AND, 16'hF0F0, 16'hFF00, 1'b1);
        check("and", 16'hF000, 1'b0, 1'b0, 1'b0);
        run(OP_OR, 16'hF0F0, 16'hFF00, 1'b1);
        check("or", 16'hFFF0, 1'b0, 1'b0, 1'b0);
        run(OP_XOR, 16'hF0F0, 16'hFF00, 1'b1);
        check("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0);
        run(OP_NOR, 16'hF0F0, 16'hFF00, 1'b1);
        check("nor", 16'h000F, 1'b0, 1'b0, 1'b0);
        run(OP_NAND, 16'hF0F0, 16'hFF00, 1'b1);
        check("nand", 16'h0FFF, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset: outputs non-zero, then reset between edges.
        run(OP_SUB, 16'h8000, 16'h0001, 1'b0);
        check("pre_reset", 16'h7FFF, 1'b1, 1'b1, 1'b1);
        drive(OP_ADD, 16'hFFFF, 16'h0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 16'h0000, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        run(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        check("post_reset", 16'h8000, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
